// File: rtl/ysyx_23060075_axi_sram_slave.sv
// ysyx_23060075_axi_sram_slave: AXI4-Lite responder over a word-addressed SRAM,
// with independent read/write FSMs and programmable response latency.
module ysyx_23060075_axi_sram_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          RD_LATENCY = 1,
    parameter int          WR_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [31:0] axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [31:0] axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready
);
    localparam logic [31:0] SPAN = 32'd4 << DEPTH_LOG2;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [1<<DEPTH_LOG2];

    function automatic logic hit(input logic [31:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] idx(input logic [31:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
    endfunction

    r_state_t    r_state, r_next;
    logic [3:0]  r_cnt, r_cnt_n;
    logic [31:0] r_addr, ra;
    logic        ar_hs, r_hs, r_enter;

    assign ar_hs   = axi_arvalid && axi_arready;
    assign r_hs    = axi_rvalid && axi_rready;
    assign ra      = ar_hs ? axi_araddr : r_addr;
    assign r_enter = r_next == R_RESP && r_state != R_RESP;

    always_comb begin
        r_next  = r_state;
        r_cnt_n = r_cnt;
        case (r_state)
            R_IDLE: if (ar_hs) begin
                r_cnt_n = 4'(RD_LATENCY);
                r_next  = RD_LATENCY == 0 ? R_RESP : R_WAIT;
            end
            R_WAIT: begin
                r_cnt_n = r_cnt - 4'd1;
                r_next  = r_cnt == 4'd1 ? R_RESP : R_WAIT;
            end
            default: r_next = r_hs ? R_IDLE : R_RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= R_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= '0;
            axi_rresp   <= '0;
        end else begin
            r_state     <= r_next;
            r_cnt       <= r_cnt_n;
            axi_arready <= r_next == R_IDLE;
            axi_rvalid  <= r_next == R_RESP;
            if (ar_hs) r_addr <= axi_araddr;
            if (r_enter) begin
                axi_rdata <= hit(ra) ? mem[idx(ra)] : '0;
                axi_rresp <= {30'd0, {2{!hit(ra)}}};
            end
        end
    end

    w_state_t    w_state, w_next;
    logic [3:0]  w_cnt, w_cnt_n, w_strb, ws;
    logic [31:0] w_addr, w_data, wa, wd;
    logic        aw_got, w_got, aw_got_n, w_got_n, aw_hs, w_hs, b_hs, w_enter;

    assign aw_hs   = axi_awvalid && axi_awready;
    assign w_hs    = axi_wvalid && axi_wready;
    assign b_hs    = axi_bvalid && axi_bready;
    assign wa      = aw_hs ? axi_awaddr : w_addr;
    assign wd      = w_hs ? axi_wdata : w_data;
    assign ws      = w_hs ? axi_wstrb : w_strb;
    assign w_enter = w_next == W_RESP && w_state != W_RESP;

    always_comb begin
        w_next   = w_state;
        w_cnt_n  = w_cnt;
        aw_got_n = aw_got || aw_hs;
        w_got_n  = w_got || w_hs;
        case (w_state)
            W_IDLE: if (aw_got_n && w_got_n) begin
                aw_got_n = 1'b0;
                w_got_n  = 1'b0;
                w_cnt_n  = 4'(WR_LATENCY);
                w_next   = WR_LATENCY == 0 ? W_RESP : W_WAIT;
            end
            W_WAIT: begin
                w_cnt_n = w_cnt - 4'd1;
                w_next  = w_cnt == 4'd1 ? W_RESP : W_WAIT;
            end
            default: w_next = b_hs ? W_IDLE : W_RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state     <= W_IDLE;
            w_cnt       <= '0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            w_addr      <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= '0;
        end else begin
            w_state     <= w_next;
            w_cnt       <= w_cnt_n;
            aw_got      <= aw_got_n;
            w_got       <= w_got_n;
            axi_awready <= w_next == W_IDLE && !aw_got_n;
            axi_wready  <= w_next == W_IDLE && !w_got_n;
            axi_bvalid  <= w_next == W_RESP;
            if (aw_hs) w_addr <= axi_awaddr;
            if (w_hs) begin
                w_data <= axi_wdata;
                w_strb <= axi_wstrb;
            end
            if (w_enter) axi_bresp <= {30'd0, {2{!hit(wa)}}};
        end
    end

    // Array has no reset; a commit racing a reset edge is dropped with its transaction.
    always_ff @(posedge clk)
        if (rst && w_enter && hit(wa))
            for (int i = 0; i < 4; i++)
                if (ws[i]) mem[idx(wa)][8*i +: 8] <= wd[8*i +: 8];
endmodule
